// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter.
// Data has priority; a starvation counter eventually forces a fetch grant.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    input  logic [2:0]        dm_width_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [2:0]        mem_width_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic              stall_f_req_o,
    output logic              stall_m_req_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [3:0] LP_LIM = 4'(STARVE_LIMIT);
    localparam logic [2:0] LP_WORD = 3'b010;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_own_f;
    logic              r_drop;
    logic [3:0]        r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [2:0]        r_mem_width;
    logic              r_if_rvalid;
    logic [31:0]       r_if_rdata;
    logic              r_dm_rvalid;
    logic [31:0]       r_dm_rdata;

    logic w_f_req;
    logic w_take;
    logic w_win_f;
    logic w_done;
    logic w_drop_now;

    // A fetch being redirected this cycle is not worth starting.
    assign w_f_req    = if_req_i & ~if_flush_i;
    assign w_take     = (r_state == S_IDLE) & (w_f_req | dm_req_i);
    assign w_win_f    = w_f_req & (~dm_req_i | (r_cnt == LP_LIM));
    assign w_done     = (r_state == S_WAIT) & mem_rvalid_i;
    assign w_drop_now = r_drop | if_flush_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_take) w_state_nxt = S_REQ;
            S_REQ:  if (mem_gnt_i) w_state_nxt = S_WAIT;
            S_WAIT: if (mem_rvalid_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_own_f     <= 1'b0;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_width <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (w_take) begin
                r_own_f     <= w_win_f;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_win_f ? 1'b0 : dm_we_i;
                r_mem_addr  <= w_win_f ? if_addr_i : dm_addr_i;
                r_mem_wdata <= w_win_f ? 32'h0 : dm_wdata_i;
                r_mem_width <= w_win_f ? LP_WORD : dm_width_i;
                if (w_win_f) begin
                    r_cnt <= '0;
                end else if (w_f_req && (r_cnt < LP_LIM)) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            if ((r_state == S_REQ) && mem_gnt_i) begin
                r_mem_req <= 1'b0;
            end
            if (w_done) begin
                r_drop <= 1'b0;
                if (!r_own_f) begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_rdata  <= mem_rdata_i;
                end else if (!w_drop_now) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= mem_rdata_i;
                end
            end else if ((r_state != S_IDLE) && r_own_f && if_flush_i) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign mem_width_o   = r_mem_width;
    assign if_rvalid_o   = r_if_rvalid;
    assign if_rdata_o    = r_if_rdata;
    assign dm_rvalid_o   = r_dm_rvalid;
    assign dm_rdata_o    = r_dm_rdata;
    assign stall_f_req_o = if_req_i & ~r_if_rvalid;
    assign stall_m_req_o = dm_req_i & ~r_dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;
    localparam int AW  = 32;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic [2:0]    dm_width_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [2:0]    mem_width_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          dm_rvalid_o;
    logic [31:0]   dm_rdata_o;
    logic          stall_f_req_o;
    logic          stall_m_req_o;

    mem_port_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_flush_i(if_flush_i),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_width_i(dm_width_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_width_o(mem_width_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .stall_f_req_o(stall_f_req_o), .stall_m_req_o(stall_m_req_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_if;
    logic [31:0] last_dm;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        flush_arb;
        logic        flush_rv;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_width;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic        exp_f;
        logic        exp_fpulse;
    } vec_t;

    vec_t tbl[8];

    // Reference model: one outstanding bus transaction, tracked abstractly.
    bit          m_pending;
    bit          m_accepted;
    bit          m_for_fetch;
    bit          m_cancel;
    int          m_losses;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_width;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_dm_rd;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_idle();
        if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0;
        dm_wdata_i = '0; dm_width_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic model_reset();
        m_pending = 0; m_accepted = 0; m_for_fetch = 0;
        m_cancel = 0; m_losses = 0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_width = '0;
        e_if_rv = 0; e_dm_rv = 0; e_if_rd = '0; e_dm_rd = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req"}, mem_req_o, 0);
        chk({nm, "_we"}, mem_we_o, 0);
        chk({nm, "_addr"}, mem_addr_o, 0);
        chk({nm, "_wdata"}, mem_wdata_o, 0);
        chk({nm, "_width"}, mem_width_o, 0);
        chk({nm, "_ifrv"}, if_rvalid_o, 0);
        chk({nm, "_ifrd"}, if_rdata_o, 0);
        chk({nm, "_dmrv"}, dm_rvalid_o, 0);
        chk({nm, "_dmrd"}, dm_rdata_o, 0);
        chk({nm, "_stf"}, stall_f_req_o, 0);
        chk({nm, "_stm"}, stall_m_req_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive_idle();
        reset_i = 0;
        #1;
        chk_all_zero("rst");
        repeat (2) @(negedge clk_i);
        reset_i = 1;
        last_if = '0;
        last_dm = '0;
        model_reset();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea;
        logic        fp;
        ea = v.exp_f ? v.f_addr : v.d_addr;
        fp = v.exp_f & v.exp_fpulse;
        if_req_i = v.f_req; if_addr_i = v.f_addr;
        if_flush_i = v.flush_arb;
        dm_req_i = v.d_req; dm_we_i = v.d_we; dm_addr_i = v.d_addr;
        dm_wdata_i = v.d_wdata; dm_width_i = v.d_width;
        mem_gnt_i = 0; mem_rvalid_i = 0;
        #1;
        chk($sformatf("v%0d_stf0", idx), stall_f_req_o, v.f_req);
        chk($sformatf("v%0d_stm0", idx), stall_m_req_o, v.d_req);
        tick();
        if_flush_i = 0;
        for (int c = 0; c <= v.gd; c++) begin
            chk($sformatf("v%0d_req", idx), mem_req_o, 1);
            chk($sformatf("v%0d_addr", idx), mem_addr_o, ea);
            chk($sformatf("v%0d_we", idx), mem_we_o, v.exp_f ? 1'b0 : v.d_we);
            chk($sformatf("v%0d_stf", idx), stall_f_req_o, v.f_req);
            if (!v.exp_f) begin
                chk($sformatf("v%0d_wd", idx), mem_wdata_o, v.d_wdata);
                chk($sformatf("v%0d_wid", idx), mem_width_o, v.d_width);
            end
            mem_gnt_i = (c == v.gd);
            tick();
        end
        mem_gnt_i = 0;
        chk($sformatf("v%0d_reqdrop", idx), mem_req_o, 0);
        repeat (v.rd) tick();
        mem_rvalid_i = 1; mem_rdata_i = v.rdata;
        if_flush_i = v.flush_rv;
        tick();
        mem_rvalid_i = 0; if_flush_i = 0;
        if (fp) last_if = v.rdata;
        if (!v.exp_f) last_dm = v.rdata;
        chk($sformatf("v%0d_ifrv", idx), if_rvalid_o, fp);
        chk($sformatf("v%0d_dmrv", idx), dm_rvalid_o, !v.exp_f);
        chk($sformatf("v%0d_ifrd", idx), if_rdata_o, last_if);
        chk($sformatf("v%0d_dmrd", idx), dm_rdata_o, last_dm);
        chk($sformatf("v%0d_stfp", idx), stall_f_req_o, v.f_req & ~fp);
        if_req_i = 0; dm_req_i = 0;
        tick();
        chk($sformatf("v%0d_ifrv1", idx), if_rvalid_o, 0);
        chk($sformatf("v%0d_dmrv1", idx), dm_rvalid_o, 0);
        chk($sformatf("v%0d_idle", idx), mem_req_o, 0);
    endtask

    // Applies the arbitration rules to the inputs present at a clock edge.
    task automatic model_step();
        bit want_f;
        bit want_d;
        bit to_f;
        e_if_rv = 0;
        e_dm_rv = 0;
        if (!m_pending) begin
            want_f = if_req_i && !if_flush_i;
            want_d = dm_req_i;
            if (want_f || want_d) begin
                to_f = want_f && (!want_d || m_losses == LIM);
                if (to_f) m_losses = 0;
                else if (want_f && m_losses < LIM) m_losses = m_losses + 1;
                m_pending = 1; m_accepted = 0;
                m_for_fetch = to_f; m_cancel = 0;
                e_req = 1;
                e_addr = to_f ? if_addr_i : dm_addr_i;
                e_we = to_f ? 1'b0 : dm_we_i;
                e_wdata = dm_wdata_i;
                e_width = dm_width_i;
            end
        end else begin
            if (m_for_fetch && if_flush_i) m_cancel = 1;
            if (!m_accepted) begin
                if (mem_gnt_i) begin
                    m_accepted = 1;
                    e_req = 0;
                end
            end else if (mem_rvalid_i) begin
                m_pending = 0;
                if (!m_for_fetch) begin
                    e_dm_rv = 1; e_dm_rd = mem_rdata_i;
                end else if (!m_cancel) begin
                    e_if_rv = 1; e_if_rd = mem_rdata_i;
                end
            end
        end
    endtask

    task automatic rand_data_req();
        dm_req_i = 1;
        dm_we_i = 1'($urandom % 2);
        dm_addr_i = $urandom;
        dm_wdata_i = $urandom;
        dm_width_i = 3'($urandom % 8);
    endtask

    int g;
    int cyc;
    logic prev_req;

    initial begin
        reset_i = 0;
        drive_idle();
        model_reset();
        last_if = '0;
        last_dm = '0;

        tbl[0] = '{1, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000,
                   0, 0, 32'h00500093, 1, 1};
        tbl[1] = '{0, 32'h0, 0, 0, 1, 0, 32'h40, 32'h0, 3'b010,
                   1, 0, 32'h11223344, 0, 0};
        tbl[2] = '{0, 32'h0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 3'b010,
                   3, 1, 32'h0, 0, 0};
        tbl[3] = '{1, 32'h104, 0, 0, 1, 0, 32'h44, 32'h0, 3'b000,
                   0, 2, 32'h000000AA, 0, 0};
        tbl[4] = '{1, 32'h200, 1, 0, 1, 1, 32'h48, 32'h5555AAAA, 3'b001,
                   1, 0, 32'h0, 0, 0};
        tbl[5] = '{1, 32'h300, 0, 1, 0, 0, 32'h0, 32'h0, 3'b000,
                   0, 0, 32'hBADBAD00, 1, 0};
        tbl[6] = '{1, 32'h304, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000,
                   2, 2, 32'hCAFEF00D, 1, 1};
        tbl[7] = '{0, 32'h0, 0, 0, 1, 1, 32'h4C, 32'h01020304, 3'b001,
                   0, 3, 32'h00000077, 0, 0};

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Starvation guard: both requesters hold, bus answers at once.
        do_reset();
        if_req_i = 1; if_addr_i = 32'hF000;
        dm_req_i = 1; dm_addr_i = 32'h8000;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
        g = 0; cyc = 0; prev_req = 0;
        while (g < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (dm_rvalid_o) dm_addr_i = dm_addr_i + 4;
            if (mem_req_o && !prev_req) begin
                g++;
                chk($sformatf("starve_g%0d", g),
                    mem_addr_o == 32'hF000, (g % 5) == 0);
            end
            prev_req = mem_req_o;
        end
        if (g < 10) chk("starve_timeout", g, 10);
        drive_idle();
        repeat (4) tick();

        // Flush while fetch waits on the bus, then redirected fetch.
        do_reset();
        if_req_i = 1; if_addr_i = 32'h500;
        tick();
        chk("fl_addr0", mem_addr_o, 32'h500);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        if_flush_i = 1; if_addr_i = 32'h600;
        tick();
        if_flush_i = 0;
        chk("fl_rv0", if_rvalid_o, 0);
        mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
        tick();
        mem_rvalid_i = 0;
        chk("fl_drop", if_rvalid_o, 0);
        chk("fl_hold", if_rdata_o, 32'h0);
        chk("fl_stall", stall_f_req_o, 1);
        tick();
        chk("fl_req2", mem_req_o, 1);
        chk("fl_addr2", mem_addr_o, 32'h600);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h000000AA;
        tick();
        mem_rvalid_i = 0;
        chk("fl_rv2", if_rvalid_o, 1);
        chk("fl_rd2", if_rdata_o, 32'h000000AA);
        if_req_i = 0;
        tick();

        // Asynchronous reset in the middle of a data transaction.
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h700;
        dm_wdata_i = 32'hA5A5A5A5; dm_width_i = 3'b010;
        tick();
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        dm_req_i = 0;
        reset_i = 0;
        #1;
        chk_all_zero("arst");
        tick();
        reset_i = 1;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h710;
        #1;
        chk("arst_req0", mem_req_o, 0);
        tick();
        chk("arst_req1", mem_req_o, 1);
        chk("arst_addr1", mem_addr_o, 32'h710);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h0BADCAFE;
        tick();
        mem_rvalid_i = 0;
        chk("arst_dmrv", dm_rvalid_o, 1);
        chk("arst_dmrd", dm_rdata_o, 32'h0BADCAFE);
        dm_req_i = 0;
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk_i);
            model_step();
            @(negedge clk_i);
            chk("r_req", mem_req_o, e_req);
            if (e_req) begin
                chk("r_addr", mem_addr_o, e_addr);
                chk("r_we", mem_we_o, e_we);
                if (!m_for_fetch) begin
                    chk("r_wdata", mem_wdata_o, e_wdata);
                    chk("r_width", mem_width_o, e_width);
                end
            end
            chk("r_ifrv", if_rvalid_o, e_if_rv);
            chk("r_dmrv", dm_rvalid_o, e_dm_rv);
            chk("r_ifrd", if_rdata_o, e_if_rd);
            chk("r_dmrd", dm_rdata_o, e_dm_rd);
            chk("r_stf", stall_f_req_o, if_req_i & ~e_if_rv);
            chk("r_stm", stall_m_req_o, dm_req_i & ~e_dm_rv);
            if (dm_req_i) begin
                if (e_dm_rv) begin
                    if ($urandom % 2 == 0) rand_data_req();
                    else dm_req_i = 0;
                end
            end else if ($urandom % 4 == 0) begin
                rand_data_req();
            end
            if_flush_i = 0;
            if (if_req_i && e_if_rv) begin
                if ($urandom % 3 != 0) if_addr_i = if_addr_i + 4;
                else if_req_i = 0;
            end else if (!if_req_i && $urandom % 3 == 0) begin
                if_req_i = 1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if ($urandom % 12 == 0) begin
                if_flush_i = 1;
                if_req_i = 1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            mem_gnt_i = 1'($urandom % 2);
            mem_rvalid_i = ($urandom % 3) == 0;
            mem_rdata_i = $urandom;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
